// File: rtl/program_loader.sv
// program_loader: writer-side companion to the CPU's 32 x 16-bit program memory.
// Packs a byte stream (high byte first) into instruction words, writes them to
// consecutive addresses from 0 and holds the CPU stalled while loading.
// Optional build macro PROGRAM_LOADER_CHECKSUM_EN adds a trailing XOR checksum
// byte that is compared against the running XOR of all accepted data bytes.
//
// state  | meaning
// IDLE   | waiting for start
// HI     | waiting for high byte of the current word
// LO     | waiting for low byte of the current word
// WRITE  | pm_we pulse for the assembled word
// CHK    | waiting for checksum byte (checksum build only)
// FINISH | one-cycle completion, then IDLE
module program_loader #(
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 32,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [5:0]        word_count,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic              pm_we,
    output logic [ADDR_W-1:0] pm_addr,
    output logic [DATA_W-1:0] pm_wdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              err
);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {S_IDLE, S_HI, S_LO, S_WRITE, S_FINISH, S_CHK} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_HI, S_LO, S_WRITE, S_FINISH} state_t;
`endif

    localparam logic [5:0] DEPTH_C = 6'(DEPTH);

    state_t     state;
    state_t     state_nxt;
    logic [5:0] cnt;
    logic [7:0] hi_byte;
    logic [5:0] cnt_in;
    logic       xfer;
    logic       start_ok;
    logic       last_word;

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [7:0] csum;
`endif

    // requests above memory depth are clamped so the address never wraps
    assign cnt_in    = (word_count > DEPTH_C) ? DEPTH_C : word_count;
    assign xfer      = byte_valid & byte_ready;
    assign start_ok  = start & (state == S_IDLE);
    // cnt is at least 1 whenever WRITE is reached, so cnt - 1 never underflows
    assign last_word = (6'(pm_addr) == (cnt - 6'd1));

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = (cnt_in == 6'd0) ? S_FINISH : S_HI;
                end
            end
            S_HI: begin
                if (xfer) state_nxt = S_LO;
            end
            S_LO: begin
                if (xfer) state_nxt = S_WRITE;
            end
            S_WRITE: begin
                if (last_word) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                    state_nxt = S_CHK;
`else
                    state_nxt = S_FINISH;
`endif
                end else begin
                    state_nxt = S_HI;
                end
            end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            S_CHK: begin
                if (xfer) state_nxt = S_FINISH;
            end
`endif
            S_FINISH: state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // outputs decoded from the registered state only, never from byte_valid
    always_comb begin
        byte_ready = 1'b0;
        pm_we      = 1'b0;
        case (state)
            S_HI:    byte_ready = 1'b1;
            S_LO:    byte_ready = 1'b1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            S_CHK:   byte_ready = 1'b1;
`endif
            S_WRITE: pm_we = 1'b1;
            default: begin
                byte_ready = 1'b0;
                pm_we      = 1'b0;
            end
        endcase
    end

    // datapath and status flags; completion flags are set on the edge entering FINISH
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            hi_byte  <= '0;
            pm_addr  <= '0;
            pm_wdata <= '0;
            busy     <= 1'b0;
            cpu_hold <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            csum     <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_ok) begin
                        // a zero-length load completes at once with an error
                        cnt      <= cnt_in;
                        pm_addr  <= '0;
                        busy     <= (cnt_in != 6'd0);
                        cpu_hold <= (cnt_in != 6'd0);
                        done     <= (cnt_in == 6'd0);
                        err      <= (cnt_in == 6'd0);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                        csum     <= '0;
`endif
                    end
                end
                S_HI: begin
                    if (xfer) begin
                        hi_byte <= byte_in;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                        csum    <= csum ^ byte_in;
`endif
                    end
                end
                S_LO: begin
                    if (xfer) begin
                        pm_wdata <= DATA_W'({hi_byte, byte_in});
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                        csum     <= csum ^ byte_in;
`endif
                    end
                end
                S_WRITE: begin
                    if (last_word) begin
`ifndef PROGRAM_LOADER_CHECKSUM_EN
                        busy     <= 1'b0;
                        cpu_hold <= 1'b0;
                        done     <= 1'b1;
`endif
                    end else begin
                        pm_addr <= pm_addr + ADDR_W'(1);
                    end
                end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                S_CHK: begin
                    if (xfer) begin
                        err      <= (byte_in != csum);
                        busy     <= 1'b0;
                        cpu_hold <= 1'b0;
                        done     <= 1'b1;
                    end
                end
`endif
                default: begin
                    cnt <= cnt;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Directed plus randomized bench for program_loader. Expected writes come from a
// byte-list model: word i = {byte[2i], byte[2i+1]} at address i, for
// i < min(count, 32). Also runs with PROGRAM_LOADER_CHECKSUM_EN defined.
module tb_program_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [5:0]  word_count;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic        pm_we;
    logic [4:0]  pm_addr;
    logic [15:0] pm_wdata;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic        err;

    program_loader dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .word_count (word_count),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .pm_we      (pm_we),
        .pm_addr    (pm_addr),
        .pm_wdata   (pm_wdata),
        .cpu_hold   (cpu_hold),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int addr;
        int data;
        int cyc;
    } wr_t;

    wr_t        obs[$];
    logic [7:0] pat[$];
    int         cyc      = 0;
    int         fall_cyc = -1;
    logic       prev_hold = 1'b0;
    int         n_checks = 0;
    int         n_fail   = 0;

    // observe writes and the cpu_hold falling edge mid-cycle
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (pm_we === 1'b1) obs.push_back('{int'(pm_addr), int'(pm_wdata), cyc});
        if (prev_hold === 1'b1 && cpu_hold === 1'b0) fall_cyc = cyc;
        prev_hold = cpu_hold;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_start(input int n);
        @(negedge clk);
        start = 1'b1;
        word_count = 6'(n);
        @(posedge clk);
        #1;
        start = 1'b0;
        check("start_busy", 32'(busy), 32'(n != 0));
        check("start_hold", 32'(cpu_hold), 32'(n != 0));
        check("start_done", 32'(done), 32'(n == 0));
        check("start_err", 32'(err), 32'(n == 0));
        check("start_addr", 32'(pm_addr), 32'd0);
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap, input bit in_lo);
        int k;
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            if (in_lo) begin
                check("gap_ready", 32'(byte_ready), 32'd1);
                check("gap_no_we", 32'(pm_we), 32'd0);
            end
        end
        @(negedge clk);
        byte_valid = 1'b1;
        byte_in = b;
        k = 0;
        while (byte_ready !== 1'b1 && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (k >= 100) begin
            check("byte_timeout", 32'd0, 32'd1);
            byte_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            byte_valid = 1'b0;
        end
    endtask

    // csum_cmd[8] selects an explicit checksum byte csum_cmd[7:0]; otherwise a
    // correct (bad=0) or corrupted (bad=1) checksum is sent in the checksum build
    task automatic run_load(input int n, input int gapmax, input bit bad,
                            input logic [8:0] csum_cmd, input bit inject);
        int         nw;
        int         k;
        logic [7:0] xsum;
        logic [7:0] sent;
        bit         exp_err;
        obs.delete();
        fall_cyc = -1;
        nw = (n > 32) ? 32 : n;
        while (pat.size() < 2 * nw) pat.push_back(8'($urandom_range(0, 255)));
        xsum = 8'h00;
        exp_err = (n == 0);
        do_start(n);
        if (inject && nw > 0) begin
            @(negedge clk);
            start = 1'b1;
            word_count = 6'd7;
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        for (int i = 0; i < 2 * nw; i++) begin
            send_byte(pat[i], (gapmax > 0) ? int'($urandom_range(0, gapmax)) : 0, (i % 2) == 1);
            xsum = xsum ^ pat[i];
        end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        if (nw > 0) begin
            if (csum_cmd[8]) sent = csum_cmd[7:0];
            else if (bad) sent = xsum ^ 8'(1 + $urandom_range(0, 254));
            else sent = xsum;
            exp_err = (sent != xsum);
            send_byte(sent, 0, 1'b0);
        end
`else
        sent = csum_cmd[7:0] ^ 8'(bad);
`endif
        k = 0;
        while (!(done === 1'b1 && busy === 1'b0) && k < 40) begin
            @(negedge clk);
            k++;
        end
        check("done_wait", 32'(k < 40), 32'd1);
        repeat (3) @(negedge clk);
        check("end_done", 32'(done), 32'd1);
        check("end_err", 32'(err), 32'(exp_err));
        check("end_busy", 32'(busy), 32'd0);
        check("end_hold", 32'(cpu_hold), 32'd0);
        check("wr_count", 32'(obs.size()), 32'(nw));
        for (int i = 0; i < nw && i < obs.size(); i++) begin
            check($sformatf("wr_addr[%0d]", i), 32'(obs[i].addr), 32'(i));
            check($sformatf("wr_data[%0d]", i), 32'(obs[i].data), 32'({pat[2*i], pat[2*i+1]}));
        end
        pat.delete();
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        word_count = 6'd0;
        byte_in = 8'h00;
        byte_valid = 1'b0;
        #12;
        check("rst_ready", 32'(byte_ready), 32'd0);
        check("rst_we", 32'(pm_we), 32'd0);
        check("rst_hold", 32'(cpu_hold), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_addr", 32'(pm_addr), 32'd0);
        check("rst_wdata", 32'(pm_wdata), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // two words, back-to-back bytes
        pat = '{8'hB2, 8'h03, 8'hB3, 8'h05};
        run_load(2, 0, 1'b0, 9'h000, 1'b0);
        if (obs.size() == 2) begin
            check("we_spacing", 32'(obs[1].cyc - obs[0].cyc), 32'd3);
`ifndef PROGRAM_LOADER_CHECKSUM_EN
            check("hold_fall", 32'(fall_cyc), 32'(obs[1].cyc + 1));
`endif
        end

        // same load with 4 idle cycles before every byte
        pat = '{8'hB2, 8'h03, 8'hB3, 8'h05};
        run_load(2, 0, 1'b0, 9'h000, 1'b0);
        pat = '{8'hB2, 8'h03, 8'hB3, 8'h05};
        obs.delete();
        do_start(2);
        for (int i = 0; i < 4; i++) send_byte(pat[i], 4, (i % 2) == 1);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        send_byte(8'hB1 ^ 8'hB3 ^ 8'h05, 0, 1'b0);
`endif
        repeat (4) @(negedge clk);
        check("gap_wr_count", 32'(obs.size()), 32'd2);
        if (obs.size() == 2) begin
            check("gap_wr0", 32'({obs[0].addr[15:0], obs[0].data[15:0]}), 32'h0000_B203);
            check("gap_wr1", 32'({obs[1].addr[15:0], obs[1].data[15:0]}), 32'h0001_B305);
        end
        check("gap_err", 32'(err), 32'd0);
        pat.delete();

        // zero length and clamped length
        run_load(0, 0, 1'b0, 9'h000, 1'b0);
        run_load(40, 0, 1'b0, 9'h000, 1'b0);

        // start during HI is ignored
        run_load(2, 1, 1'b0, 9'h000, 1'b1);

        // reset after 3 words of a 5-word load
        obs.delete();
        do_start(5);
        for (int i = 0; i < 6; i++) send_byte(8'($urandom_range(0, 255)), 0, (i % 2) == 1);
        @(negedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_we", 32'(pm_we), 32'd0);
        check("mid_rst_ready", 32'(byte_ready), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_hold", 32'(cpu_hold), 32'd0);
        check("mid_rst_addr", 32'(pm_addr), 32'd0);
        check("mid_rst_wdata", 32'(pm_wdata), 32'd0);
        check("pre_rst_writes", 32'(obs.size()), 32'd3);
        @(negedge clk);
        rst = 1'b0;
        byte_valid = 1'b1;
        byte_in = 8'h5A;
        repeat (10) @(negedge clk);
        byte_valid = 1'b0;
        check("post_rst_writes", 32'(obs.size()), 32'd3);
        check("post_rst_done", 32'(done), 32'd0);
        check("post_rst_busy", 32'(busy), 32'd0);
        run_load(5, 0, 1'b0, 9'h000, 1'b0);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
        pat = '{8'hB2, 8'h03};
        run_load(1, 0, 1'b0, 9'h1B1, 1'b0);
        pat = '{8'hB2, 8'h03};
        run_load(1, 0, 1'b0, 9'h100, 1'b0);
`endif

        // randomized loads
        for (int r = 0; r < 6; r++) begin
            run_load(int'($urandom_range(1, 40)), int'($urandom_range(0, 2)),
                     1'($urandom_range(0, 1)), 9'h000, 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Writer-side companion to the CPU's 32 x 16-bit program memory.
- Accepts a byte stream over a valid/ready handshake and packs byte pairs (high byte first) into 16-bit instruction words.
- Writes words to consecutive program-memory addresses starting at 0.
- Holds the CPU in stall while loading so new programs can be installed without re-synthesis.

Parameters:
- ADDR_W, 5, program-memory address width.
- DEPTH, 32, number of instruction words in program memory.
- DATA_W, 16, instruction word width; fixed at 2 bytes.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle request to begin a load.
- word_count  input  6  number of words to load; sampled on accepted start.
- byte_in  input  8  incoming data byte.
- byte_valid  input  1  byte_in is valid.
- byte_ready  output  1  loader accepts byte_in this cycle.
- pm_we  output  1  program-memory write strobe, one cycle per word.
- pm_addr  output  ADDR_W  program-memory write address.
- pm_wdata  output  DATA_W  program-memory write data.
- cpu_hold  output  1  stall request to the CPU while loading.
- busy  output  1  load in progress.
- done  output  1  sticky; load finished.
- err  output  1  sticky; load finished with error.

Behaviour:
- Reset (asynchronous, active-high, immediate):
  - State = IDLE.
  - byte_ready, pm_we, cpu_hold, busy, done, err = 0.
  - pm_addr, pm_wdata, word counter and byte latch = 0.
  - Reset mid-load abandons the load; no further pm_we pulses. Words already written stay in memory.
- A byte transfer occurs on a clock edge where byte_valid=1 and byte_ready=1. byte_ready is a registered function of state only and never depends on byte_valid.
- IDLE:
  - byte_ready=0.
  - start=1 → clear done and err, latch count, pm_addr=0, busy=1, cpu_hold=1, go to HI.
  - count handling: word_count=0 → no writes; next cycle done=1, err=1, busy=0, cpu_hold=0. word_count>DEPTH → clamp to DEPTH.
- HI:
  - byte_ready=1.
  - On transfer, latch byte as bits [15:8], go to LO.
  - With no transfer, stay indefinitely; there is no timeout.
- LO:
  - byte_ready=1.
  - On transfer, pm_wdata={hi,byte}, go to WRITE.
- WRITE:
  - byte_ready=0, pm_we=1 for exactly this cycle, with pm_addr/pm_wdata stable.
  - If pm_addr==count-1, go to FINISH. Otherwise pm_addr increments on exit and the next state is HI.
  - pm_addr never wraps; the last write is at most DEPTH-1.
- FINISH:
  - One cycle; busy=0, cpu_hold=0, done=1, then IDLE.
  - done and err hold until the next accepted start or reset.
- start is ignored in every state except IDLE, including the FINISH cycle.
- Timing:
  - Minimum 3 cycles per word; full 32-word load takes ≥96 cycles plus 2.
  - Write latency: pm_we asserts the cycle after the low-byte transfer.
- cpu_hold rises the cycle after an accepted start and falls with busy. The CPU does not fetch while it is high.

Optional Feature:
- Macro: PROGRAM_LOADER_CHECKSUM_EN.
- Defined:
  - An 8-bit running XOR of every data byte accepted is kept; it is cleared on start.
  - After the last WRITE, go to CHK instead of FINISH. In CHK, byte_ready=1; accept exactly one byte.
  - err=1 if that byte ≠ running XOR, otherwise err=0. Then go to FINISH.
  - busy and cpu_hold stay high through CHK.
  - word_count=0 still errors immediately; no checksum byte is consumed.
- Not defined:
  - No CHK state, no XOR logic.
  - err is set only by word_count=0.

Test Plan:
- Count 2, back-to-back bytes B2,03,B3,05 → pm_we pulses: addr0/0xB203, then addr1/0xB305, 3 cycles apart. Then done=1, err=0, cpu_hold falls the cycle after the 2nd pm_we.
- Same load with byte_valid low for 4 cycles between each byte → identical writes. byte_ready stays high while waiting and pm_we never asserts early.
- word_count=0 → no pm_we, done=1 and err=1 one cycle after start. word_count=40 → exactly 32 writes at addr 0..31, no wrap.
- start pulsed during HI of an active load → ignored; addr sequence and count unchanged.
- rst asserted after 3 words of a 5-word load → outputs zero immediately; after release, no pm_we and done=0. A new start then reloads from addr 0.
- (PROGRAM_LOADER_CHECKSUM_EN) Bytes B2,03 then checksum B1 → err=0, done=1. Repeat with checksum 00 → err=1, done=1. Both runs show exactly one pm_we.
